// File: rtl/master_arbiter_ar_pkg.sv
// Shared definitions for the AR arbiter: master indices, FSM encodings and
// the index-to-one-hot decode used for both the AR and R selects.
package master_arbiter_ar_pkg;

    localparam logic [1:0] AXI_MASTER_0 = 2'd0;
    localparam logic [1:0] AXI_MASTER_1 = 2'd1;
    localparam logic [1:0] AXI_MASTER_2 = 2'd2;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    function automatic logic [2:0] idx2oh(input logic [1:0] idx);
        logic [2:0] oh;
        oh = '0;
        case (idx)
            AXI_MASTER_0: oh = 3'b001;
            AXI_MASTER_1: oh = 3'b010;
            AXI_MASTER_2: oh = 3'b100;
            default:      oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/master_arbiter_ar_fifo.sv
// In-order FIFO of granted master indices; the head steers returning read data.
module arb_ord_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is only legal when a pop frees a slot in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/master_arbiter_ar.sv
// Read-address arbiter for three masters: rotating priority, grant held until
// the AR handshake, and an in-order FIFO that routes R bursts back to their issuer.
module master_arbiter_ar
    import master_arbiter_ar_pkg::*;
#(
    parameter int unsigned OT_DEPTH = 4,
    parameter int unsigned IDX_W    = 2,
    localparam int unsigned CNT_W   = $clog2(OT_DEPTH) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             m0_arvalid,
    input  logic             m1_arvalid,
    input  logic             m2_arvalid,
    input  logic             s_arready,
    input  logic             s_rvalid,
    input  logic             s_rlast,
    input  logic             m_rready,
    output logic [2:0]       ar_sel,
    output logic             ar_gnt_valid,
    output logic [2:0]       r_sel,
    output logic [CNT_W-1:0] ord_count,
    output logic             ord_full,
    output logic             r_orphan
);

    logic [0:0]       state;
    logic [1:0]       cur_prio;
    logic [1:0]       gnt_idx;
    logic [2:0]       req;
    logic             win_found;
    logic [1:0]       win_idx;
    logic             ar_hs;
    logic             r_last_beat;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic [IDX_W-1:0] push_idx;
    logic [1:0]       next_prio;

    assign req          = {m2_arvalid, m1_arvalid, m0_arvalid};
    assign ar_gnt_valid = |ar_sel;
    assign ar_hs        = (state == ARB_GRANT) && s_arready && |(ar_sel & req);
    assign r_last_beat  = s_rvalid && m_rready && s_rlast;
    assign push_idx     = IDX_W'(gnt_idx);
    assign next_prio    = (gnt_idx == AXI_MASTER_2) ? AXI_MASTER_0 : gnt_idx + 2'd1;
    assign r_sel        = fifo_empty ? 3'b000 : idx2oh(fifo_head[1:0]);

    // walk cur_prio, cur_prio+1, cur_prio+2 (mod 3); first requester wins
    always_comb begin
        logic [2:0] sum;
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = AXI_MASTER_0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum = {1'b0, cur_prio} + 3'(i);
            if (sum >= 3'd3) begin
                sum = sum - 3'd3;
            end
            cand = sum[1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ARB_IDLE;
            ar_sel   <= '0;
            gnt_idx  <= AXI_MASTER_0;
            cur_prio <= AXI_MASTER_0;
            r_orphan <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_found && !ord_full) begin
                        ar_sel  <= idx2oh(win_idx);
                        gnt_idx <= win_idx;
                        state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (ar_hs) begin
                        cur_prio <= next_prio;
                        ar_sel   <= '0;
                        state    <= ARB_IDLE;
                    end
                end
                default: begin
                    ar_sel <= '0;
                    state  <= ARB_IDLE;
                end
            endcase
            if (r_last_beat && fifo_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    arb_ord_fifo #(
        .DEPTH (OT_DEPTH),
        .WIDTH (IDX_W)
    ) u_ord_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (ar_hs),
        .push_data (push_idx),
        .pop       (r_last_beat),
        .head      (fifo_head),
        .count     (ord_count),
        .full      (ord_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_master_arbiter_ar.sv
// Directed plus random stimulus against a queue-based reference of the AR arbiter.
module tb_master_arbiter_ar;

    localparam int DEPTH = 4;

    logic       sys_clk;
    logic       sys_rst;
    logic [2:0] arv;
    logic       s_arready;
    logic       s_rvalid;
    logic       s_rlast;
    logic       m_rready;
    logic [2:0] ar_sel;
    logic       ar_gnt_valid;
    logic [2:0] r_sel;
    logic [2:0] ord_count;
    logic       ord_full;
    logic       r_orphan;

    int checks = 0;
    int errors = 0;

    // reference: granted master (-1 = none), rotating priority, outstanding queue
    int m_gnt;
    int m_prio;
    int q[$];
    bit m_orph;

    master_arbiter_ar #(
        .OT_DEPTH (4),
        .IDX_W    (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .m0_arvalid   (arv[0]),
        .m1_arvalid   (arv[1]),
        .m2_arvalid   (arv[2]),
        .s_arready    (s_arready),
        .s_rvalid     (s_rvalid),
        .s_rlast      (s_rlast),
        .m_rready     (m_rready),
        .ar_sel       (ar_sel),
        .ar_gnt_valid (ar_gnt_valid),
        .r_sel        (r_sel),
        .ord_count    (ord_count),
        .ord_full     (ord_full),
        .r_orphan     (r_orphan)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  pre;
        int  next_gnt;
        bit  do_push;
        if (sys_rst) begin
            q.delete();
            m_gnt  = -1;
            m_prio = 0;
            m_orph = 1'b0;
            return;
        end
        pre      = q.size();
        next_gnt = m_gnt;
        do_push  = 1'b0;
        if (m_gnt < 0) begin
            if (pre < DEPTH) begin
                for (int k = 0; k < 3; k++) begin
                    int c;
                    c = (m_prio + k) % 3;
                    if (arv[c]) begin
                        next_gnt = c;
                        break;
                    end
                end
            end
        end else if (s_arready && arv[m_gnt]) begin
            do_push  = 1'b1;
            m_prio   = (m_gnt + 1) % 3;
            next_gnt = -1;
        end
        if (s_rvalid && m_rready && s_rlast) begin
            if (pre > 0) void'(q.pop_front());
            else m_orph = 1'b1;
        end
        if (do_push) q.push_back(m_gnt);
        m_gnt = next_gnt;
    endtask

    task automatic check_model();
        logic [2:0] e_ar;
        logic [2:0] e_r;
        e_ar = (m_gnt < 0) ? 3'b000 : 3'(1 << m_gnt);
        e_r  = (q.size() == 0) ? 3'b000 : 3'(1 << q[0]);
        chk("ar_sel", 32'(ar_sel), 32'(e_ar));
        chk("ar_gnt_valid", 32'(ar_gnt_valid), 32'(e_ar != 3'b000));
        chk("r_sel", 32'(r_sel), 32'(e_r));
        chk("ord_count", 32'(ord_count), 32'(q.size()));
        chk("ord_full", 32'(ord_full), 32'(q.size() == DEPTH));
        chk("r_orphan", 32'(r_orphan), 32'(m_orph));
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_r(input logic v, input logic l, input logic rdy);
        s_rvalid = v;
        s_rlast  = l;
        m_rready = rdy;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        arv     = 3'b000;
        s_arready = 1'b0;
        set_r(1'b0, 1'b0, 1'b0);
        step();
        sys_rst = 1'b0;
    endtask

    initial begin
        m_gnt = -1;
        m_prio = 0;
        m_orph = 1'b0;
        sys_rst = 1'b1;
        arv = 3'b000;
        s_arready = 1'b0;
        set_r(1'b0, 1'b0, 1'b0);

        // single request, handshake one cycle after grant
        do_reset();
        chk("rst_ar_sel", 32'(ar_sel), 32'd0);
        chk("rst_count", 32'(ord_count), 32'd0);
        arv = 3'b001;
        step();
        chk("t1_grant", 32'(ar_sel), 32'b001);
        s_arready = 1'b1;
        step();
        chk("t1_release", 32'(ar_sel), 32'b000);
        chk("t1_count", 32'(ord_count), 32'd1);
        chk("t1_r_sel", 32'(r_sel), 32'b001);

        // all requesting: m0,m1,m2,m0 then stall on full
        do_reset();
        arv = 3'b111;
        s_arready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t2_full", 32'(ord_full), 32'd1);
        chk("t2_no5th", 32'(ar_sel), 32'd0);

        // full with m2 pending: pop releases a slot, m2 granted next cycle
        arv = 3'b100;
        s_arready = 1'b0;
        step();
        set_r(1'b1, 1'b1, 1'b1);
        step();
        chk("t4_notfull", 32'(ord_full), 32'd0);
        chk("t4_wait", 32'(ar_sel), 32'd0);
        set_r(1'b0, 1'b0, 1'b0);
        step();
        chk("t4_m2_gnt", 32'(ar_sel), 32'b100);
        s_arready = 1'b1;
        set_r(1'b1, 1'b1, 1'b1);
        step();
        chk("t4_push_pop", 32'(ord_count), 32'd3);
        set_r(1'b0, 1'b0, 1'b0);
        arv = 3'b000;
        step();

        // m1 then m0 outstanding; 3-beat burst returns to m1
        do_reset();
        s_arready = 1'b1;
        arv = 3'b010;
        step();
        step();
        arv = 3'b001;
        step();
        step();
        arv = 3'b000;
        chk("t3_head", 32'(r_sel), 32'b010);
        set_r(1'b1, 1'b0, 1'b1);
        step();
        step();
        chk("t3_beat2", 32'(r_sel), 32'b010);
        set_r(1'b1, 1'b1, 1'b1);
        step();
        chk("t3_after", 32'(r_sel), 32'b001);
        chk("t3_count", 32'(ord_count), 32'd1);
        set_r(1'b0, 1'b0, 1'b0);
        step();

        // orphan last beat on empty queue is sticky
        do_reset();
        set_r(1'b1, 1'b1, 1'b1);
        step();
        set_r(1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("t5_orphan", 32'(r_orphan), 32'd1);
        chk("t5_count", 32'(ord_count), 32'd0);

        // reset while a grant is held with two outstanding
        do_reset();
        arv = 3'b011;
        s_arready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s_arready = 1'b0;
        step();
        chk("t6_pre", 32'(ar_sel), 32'b001);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("t6_ar_sel", 32'(ar_sel), 32'd0);
        chk("t6_count", 32'(ord_count), 32'd0);
        chk("t6_r_sel", 32'(r_sel), 32'd0);

        // random traffic including illegal arvalid drops and occasional resets
        for (int i = 0; i < 800; i++) begin
            arv       = 3'($urandom_range(0, 7));
            s_arready = 1'($urandom_range(0, 1));
            s_rvalid  = 1'($urandom_range(0, 1));
            m_rready  = 1'($urandom_range(0, 1));
            s_rlast   = ($urandom_range(0, 2) == 0);
            sys_rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        sys_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
